// File: rtl/two_to_four_decoder_pkg.sv
// Shared widths, types and polarity helper for the two_to_four_decoder block.
package two_to_four_decoder_pkg;

  localparam int SEL_W_DEF = 2;
  localparam int OUT_W_DEF = 4;

  typedef logic [SEL_W_DEF-1:0] sel_t;
  typedef logic [OUT_W_DEF-1:0] onehot_t;

  // Pattern driven on b when no line is selected; also the polarity XOR mask.
  function automatic onehot_t inactive_pattern(input bit active_low);
    return active_low ? '1 : '0;
  endfunction

endpackage

// File: rtl/dec_onehot_core.sv
// Combinational SEL_W -> 2**SEL_W one-hot decode gated by en; zero latency.
// No flow control: output follows inputs continuously.
module dec_onehot_core #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]      a,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] y
);

  always_comb begin
    y = '0;
    if (en) y[a] = 1'b1;
  end

endmodule

// File: rtl/two_to_four_decoder.sv
// Registered 2-to-4 decoder with enable; one-clock latency, no backpressure (accepts every cycle).
// Optional one-hot checker output err and assertions under TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN.
module two_to_four_decoder
  import two_to_four_decoder_pkg::*;
#(
  parameter int SEL_W          = SEL_W_DEF,
  parameter int ACTIVE_LOW_OUT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_W-1:0]      a,
  input  logic                  en,
  output logic [(1<<SEL_W)-1:0] b,
  output logic                  vld
`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int OUT_W = 1 << SEL_W;
  localparam onehot_t INACT_DEF = inactive_pattern(ACTIVE_LOW_OUT != 0);
  localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{INACT_DEF[0]}};

  logic [OUT_W-1:0] dec;
  logic [OUT_W-1:0] b_d;
  logic [OUT_W-1:0] b_q;
  logic             vld_q;

  dec_onehot_core #(.SEL_W(SEL_W)) u_core (
    .a  (a),
    .en (en),
    .y  (dec)
  );

  // Inverting against the inactive pattern applies the output polarity.
  assign b_d = dec ^ INACTIVE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      b_q   <= INACTIVE;
      vld_q <= 1'b0;
    end else begin
      b_q   <= b_d;
      vld_q <= en;
    end
  end

  assign b   = b_q;
  assign vld = vld_q;

`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
  logic [OUT_W-1:0] b_act;
  logic             onehot;
  logic             err_d;
  logic             err_q;

  assign b_act  = b_q ^ INACTIVE;
  assign onehot = (b_act != '0) && ((b_act & (b_act - 1'b1)) == '0);
  assign err_d  = vld_q ? !onehot : (b_act != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;

  a_live_onehot: assert property (@(posedge clk) disable iff (!rst_n) vld_q |-> onehot);
  a_idle_clear:  assert property (@(posedge clk) disable iff (!rst_n) !vld_q |-> (b_act == '0));
`endif

endmodule

// File: tb/tb_two_to_four_decoder.sv
// Randomised and directed bench for two_to_four_decoder, both output polarities.
module tb_two_to_four_decoder;
  import two_to_four_decoder_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  sel_t    a;
  logic    en;
  onehot_t b0, b1;
  logic    vld0, vld1;
`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
  logic    err0, err1;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  two_to_four_decoder #(.SEL_W(2), .ACTIVE_LOW_OUT(0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .b(b0), .vld(vld0)
`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
    , .err(err0)
`endif
  );

  two_to_four_decoder #(.SEL_W(2), .ACTIVE_LOW_OUT(1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .a(a), .en(en), .b(b1), .vld(vld1)
`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
    , .err(err1)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a live decode is the single bit 2**a; anything else is all-inactive.
  task automatic apply(input sel_t ai, input logic eni, input logic rsti);
    onehot_t exp_b;
    logic    exp_v;
    @(negedge clk);
    a     = ai;
    en    = eni;
    rst_n = rsti;
    @(posedge clk);
    #1;
    exp_v = rsti && eni;
    exp_b = exp_v ? onehot_t'(1 << ai) : 4'b0000;
    chk("b_hi",   b0,   exp_b);
    chk("vld_hi", {3'b0, vld0}, {3'b0, exp_v});
    chk("b_lo",   b1,   ~exp_b);
    chk("vld_lo", {3'b0, vld1}, {3'b0, exp_v});
`ifdef TWO_TO_FOUR_DECODER_ONEHOT_CHECK_EN
    chk("err_hi", {3'b0, err0}, 4'b0);
    chk("err_lo", {3'b0, err1}, 4'b0);
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a     = 2'b00;
    en    = 1'b0;

    // Reset overrides en, then first live decode on the release edge.
    for (int i = 0; i < 3; i++) apply(2'b11, 1'b1, 1'b0);
    apply(2'b11, 1'b1, 1'b1);

    // Enabled sweep.
    for (int i = 0; i < 4; i++) apply(sel_t'(i), 1'b1, 1'b1);

    // Disabled, then re-enable.
    apply(2'b00, 1'b0, 1'b1);
    apply(2'b01, 1'b0, 1'b1);
    apply(2'b11, 1'b0, 1'b1);
    apply(2'b10, 1'b1, 1'b1);

    // Mid-operation reset.
    apply(2'b01, 1'b1, 1'b1);
    apply(2'b01, 1'b1, 1'b0);
    apply(2'b01, 1'b1, 1'b1);

    // Code change and simultaneous disable.
    apply(2'b00, 1'b1, 1'b1);
    apply(2'b11, 1'b0, 1'b1);

    // Full (a, en) sweep.
    for (int i = 0; i < 8; i++) apply(sel_t'(i % 4), i[2], 1'b1);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++)
      apply(sel_t'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
            ($urandom_range(19, 0) != 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
